// File: rtl/cpu_pkg.sv
// Shared core definitions: branch condition codes, flag bit positions and the
// 16-bit adder used by datapath blocks of that width.
package cpu_pkg;

   typedef enum logic [2:0] {
      NEQ    = 3'b000,
      EQ     = 3'b001,
      GT     = 3'b010,
      LT     = 3'b011,
      GTE    = 3'b100,
      LTE    = 3'b101,
      OVFL   = 3'b110,
      UNCOND = 3'b111
   } cond_t;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_N = 2;

   function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Maps a 3-bit branch condition code and the N/V/Z flags to a hit signal.
// Purely combinational.
module branch_cond
   import cpu_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] flags,
   output logic       hit
);

   logic z;
   logic v;
   logic n;

   assign z = flags[FLAG_Z];
   assign v = flags[FLAG_V];
   assign n = flags[FLAG_N];

   always_comb begin
      hit = 1'b0;
      unique case (cond_t'(cond))
         NEQ:    hit = !z;
         EQ:     hit = z;
         GT:     hit = !z && !n;
         LT:     hit = n;
         GTE:    hit = z || (!z && !n);
         LTE:    hit = n || z;
         OVFL:   hit = v;
         UNCOND: hit = 1'b1;
         default: hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection, halt state, branch
// flush pulse and a saturating taken-branch counter.
module pc_unit
   import cpu_pkg::*;
#(
   parameter int unsigned         PC_W     = 16,
   parameter int unsigned         OFF_W    = 9,
   parameter int unsigned         INC      = 2,
   parameter logic [PC_W-1:0]     RESET_PC = '0,
   parameter int unsigned         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             br,
   input  logic             br_reg,
   input  logic [2:0]       cond,
   input  logic [2:0]       flags,
   input  logic [OFF_W-1:0] offset,
   input  logic [PC_W-1:0]  reg_target,
   input  logic             hlt,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  pc_plus,
   output logic             taken,
   output logic             flush,
   output logic             halted,
   output logic [CNT_W-1:0] br_count
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             flush_q, flush_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             hit;
   logic [PC_W-1:0]  off_sx;
   logic [PC_W-1:0]  off_bytes;
   logic [PC_W-1:0]  rel_target;
   logic [PC_W-1:0]  target;
   logic             commit;

   branch_cond u_branch_cond (
      .cond  (cond),
      .flags (flags),
      .hit   (hit)
   );

   // Offset counts 16-bit words; sign-extend then scale to bytes.
   assign off_sx    = PC_W'($signed(offset));
   assign off_bytes = {off_sx[PC_W-2:0], 1'b0};

   generate
      if (PC_W == 16) begin : g_add16
         assign pc_plus    = add16(pc_q, 16'(INC));
         assign rel_target = add16(pc_plus, off_bytes);
      end else begin : g_add_native
         assign pc_plus    = pc_q + PC_W'(INC);
         assign rel_target = pc_plus + off_bytes;
      end
   endgenerate

   assign target = br_reg ? reg_target : rel_target;
   assign halted = (state_q == ST_HALTED);
   assign taken  = br && hit && !halted && !hlt;
   assign commit = taken && !stall;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
      cnt_d   = cnt_q;
      if (state_q == ST_RUN && !stall) begin
         if (hlt) begin
            state_d = ST_HALTED;
         end else if (taken) begin
            pc_d = target;
         end else begin
            pc_d = pc_plus;
         end
      end
      if (commit) begin
         flush_d = 1'b1;
         if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         flush_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flush_q <= flush_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc       = pc_q;
   assign flush    = flush_q;
   assign br_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios followed by random traffic,
// checked against an arithmetic reference model of the PC unit.
module tb_pc_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        br;
   logic        br_reg;
   logic [2:0]  cond;
   logic [2:0]  flags;
   logic [8:0]  offset;
   logic [15:0] reg_target;
   logic        hlt;

   logic [15:0] pc, pc_plus;
   logic        taken, flush, halted;
   logic [15:0] br_count;

   logic [15:0] pc2, pc_plus2;
   logic        taken2, flush2, halted2;
   logic [1:0]  br_count2;

   pc_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .br(br), .br_reg(br_reg), .cond(cond),
      .flags(flags), .offset(offset), .reg_target(reg_target), .hlt(hlt),
      .pc(pc), .pc_plus(pc_plus), .taken(taken), .flush(flush), .halted(halted),
      .br_count(br_count)
   );

   pc_unit #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .stall(stall), .br(br), .br_reg(br_reg), .cond(cond),
      .flags(flags), .offset(offset), .reg_target(reg_target), .hlt(hlt),
      .pc(pc2), .pc_plus(pc_plus2), .taken(taken2), .flush(flush2), .halted(halted2),
      .br_count(br_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] pc_plus;
      logic        taken;
      logic        flush;
      logic        halted;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t q[$];

   int vectors = 0;
   int errors  = 0;

   // Reference model state
   logic [15:0] m_pc;
   logic        m_halted;
   logic        m_flush;
   logic [15:0] m_cnt;
   logic [1:0]  m_cnt2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic bit cond_hit(input logic [2:0] c, input logic [2:0] f);
      bit z, v, n;
      z = f[0];
      v = f[1];
      n = f[2];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || (!z && !n);
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_reset();
      m_pc     = 16'h0000;
      m_halted = 1'b0;
      m_flush  = 1'b0;
      m_cnt    = 16'h0000;
      m_cnt2   = 2'd0;
   endtask

   // Applies one cycle of inputs (called just after a rising edge), queues the
   // expected outputs for this cycle, advances the model and waits one cycle.
   task automatic drive(input bit i_br, input bit i_br_reg, input logic [2:0] i_cond,
                        input logic [2:0] i_flags, input logic [8:0] i_off,
                        input logic [15:0] i_rt, input bit i_hlt, input bit i_stall);
      exp_t e;
      bit   tk;
      int   soff;
      br = i_br; br_reg = i_br_reg; cond = i_cond; flags = i_flags;
      offset = i_off; reg_target = i_rt; hlt = i_hlt; stall = i_stall;
      tk = i_br && cond_hit(i_cond, i_flags) && !m_halted && !i_hlt;
      e.pc = m_pc; e.pc_plus = 16'((int'(m_pc) + 2) % 65536); e.taken = tk;
      e.flush = m_flush; e.halted = m_halted; e.cnt = m_cnt; e.cnt2 = m_cnt2;
      q.push_back(e);
      m_flush = 1'b0;
      if (!m_halted && !i_stall) begin
         if (i_hlt) begin
            m_halted = 1'b1;
         end else if (tk) begin
            soff = (i_off >= 9'd256) ? int'(i_off) - 512 : int'(i_off);
            m_pc = i_br_reg ? i_rt : 16'((int'(m_pc) + 2 + 2 * soff) & 32'hFFFF);
            m_flush = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
         end else begin
            m_pc = 16'((int'(m_pc) + 2) % 65536);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 3'd0, 3'd0, 9'd0, 16'h0, 0, 0);
   endtask

   task automatic jump(input logic [15:0] t);
      drive(1, 1, 3'd7, 3'd0, 9'd0, t, 0, 0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_pc"}, 32'(pc), 32'h0);
      chk({tag, "_halted"}, 32'(halted), 32'h0);
      chk({tag, "_flush"}, 32'(flush), 32'h0);
      chk({tag, "_count"}, 32'(br_count), 32'h0);
      chk({tag, "_count_sat"}, 32'(br_count2), 32'h0);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear before any edge.
   task automatic async_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("async_rst");
      br = 0; hlt = 0; stall = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Monitor: compares queued expectations against the DUT mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", 32'(pc), 32'(e.pc));
            chk("pc_plus", 32'(pc_plus), 32'(e.pc_plus));
            chk("taken", 32'(taken), 32'(e.taken));
            chk("flush", 32'(flush), 32'(e.flush));
            chk("halted", 32'(halted), 32'(e.halted));
            chk("br_count", 32'(br_count), 32'(e.cnt));
            chk("br_count_sat", 32'(br_count2), 32'(e.cnt2));
         end
      end
   end

   initial begin
      rst = 1'b1; stall = 0; br = 0; br_reg = 0; cond = 0; flags = 0;
      offset = 0; reg_target = 0; hlt = 0;
      model_reset();
      #3;
      check_reset_state("por");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Sequential fetch after reset
      repeat (4) idle();

      // Relative branch taken (Z=1) and not taken (Z=0), offset -2 words
      jump(16'h0010);
      drive(1, 0, 3'd1, 3'b001, 9'h1FE, 16'h0, 0, 0);
      idle();
      idle();
      jump(16'h0010);
      drive(1, 0, 3'd1, 3'b000, 9'h1FE, 16'h0, 0, 0);
      idle();

      // Full condition sweep
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            drive(1, 0, 3'(c), 3'(f), 9'(($urandom_range(0, 15) - 8) & 9'h1FF), 16'h0, 0, 0);
         end
      end

      // Register target, first stalled then committed
      drive(1, 1, 3'd7, 3'd0, 9'd0, 16'h1234, 0, 1);
      drive(1, 1, 3'd7, 3'd0, 9'd0, 16'h1234, 0, 0);
      idle();
      idle();

      // Wrap-around
      jump(16'hFFFE);
      idle();
      idle();

      // HLT together with a branch, then hold with noisy inputs
      jump(16'h0040);
      drive(1, 0, 3'd7, 3'd0, 9'd5, 16'h0, 1, 0);
      for (int i = 0; i < 10; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 9'($urandom), 16'($urandom), 0,
               $urandom_range(0, 1));
      end
      async_reset();
      idle();

      // Counter saturation on the 2-bit instance
      for (int i = 0; i < 5; i++) drive(1, 0, 3'd7, 3'd0, 9'd1, 16'h0, 0, 0);
      idle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if (m_halted && $urandom_range(0, 7) == 0) begin
            async_reset();
         end else begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 9'($urandom), 16'($urandom),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0);
         end
      end

      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      #1;
      chk("scoreboard_drain", 32'(q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-issue core. It holds the architectural PC register and evaluates the 3-bit branch condition against the N/V/Z flags. It selects the next PC from sequential increment, a PC-relative target or a register target, and handles stall, halt and branch-flush signalling. It sits between the fetch address port and the decode/flag logic. A saturating taken-branch counter provides performance visibility.

## Interface
- `PC_W`, 16: PC and address width.
- `OFF_W`, 9: width of the signed branch offset field.
- `INC`, 2: sequential increment in bytes.
- `RESET_PC`, 0: PC value loaded on reset.
- `CNT_W`, 16: width of the taken-branch counter.

- `clk`  in  1  Sole clock. All state updates on the rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `stall`  in  1  Hold the PC and all state this cycle.
- `br`  in  1  Current instruction is a conditional branch.
- `br_reg`  in  1  Branch target comes from `reg_target`, not from the offset. Only meaningful with `br`.
- `cond`  in  3  Branch condition code.
- `flags`  in  3  Condition flags: [0]=Z, [1]=V, [2]=N.
- `offset`  in  OFF_W  Signed word offset.
- `reg_target`  in  PC_W  Register-sourced target address.
- `hlt`  in  1  Current instruction is HLT.
- `pc`  out  PC_W  Current fetch address.
- `pc_plus`  out  PC_W  `pc + INC`, combinational. Used for PCS/link writes.
- `taken`  out  1  Combinational. The branch is taken this cycle.
- `flush`  out  1  Registered one-cycle pulse after a taken branch commits.
- `halted`  out  1  Processor is halted.
- `br_count`  out  CNT_W  Saturating count of committed taken branches.

## Operation
- Condition table, evaluated as `hit`:
  - 000 `Z==0`
  - 001 `Z==1`
  - 010 `Z==0 && N==0`
  - 011 `N==1`
  - 100 `Z==1 || (Z==0 && N==0)`
  - 101 `N==1 || Z==1`
  - 110 `V==1`
  - 111 always
- `taken = br && hit && !halted && !hlt`.
- Relative target: `pc_plus + (sext(offset) << 1)`, computed at `PC_W` bits. All additions wrap modulo 2^PC_W. No overflow is reported.
- Target selection: `br_reg` selects `reg_target`. Otherwise the relative target is used.
- State machine, two states:
  - RUN: the reset state.
  - HALTED: entered from RUN when `hlt && !stall`.
  - HALTED is left only by `rst`.
- Next-PC priority, highest first:
  1. `rst` loads `RESET_PC`.
  2. HALTED holds.
  3. `stall` holds.
  4. `hlt` holds the PC at the HLT address and enters HALTED.
  5. `taken` loads the target.
  6. Otherwise `pc_plus`.
- `br` and `hlt` asserted together: `hlt` wins. The branch is not taken and not counted.
- `br_count` increments on every committed taken branch (taken and not stalled). It saturates at all-ones.
- `flush` is set on a committed taken branch and cleared the following cycle. A stalled taken branch does not assert `flush`.

## Timing
- Reset values:
  - `pc` = `RESET_PC`
  - `flush` = 0
  - `halted` = 0
  - `br_count` = 0
  - state = RUN
- `rst` asserted mid-operation clears all of the above immediately, without waiting for a clock edge.
- `taken`, `pc_plus` and the next-PC value are combinational from the current `pc` and inputs. `pc` updates on the next edge, giving a 1-cycle latency.
- `flush` is high exactly one cycle, in the cycle after the taken branch's edge.
- `halted` rises on the edge that commits HLT. `pc` is unchanged across that edge.
- `stall` during HALTED has no effect.
- Wrap-around example: `pc` = `{PC_W{1}} - 1` with no branch gives next `pc` = 0.

## Structure
- Shared package `cpu_pkg` holds:
  - the `cond_t` enum, with encodings 000–111 named NEQ, EQ, GT, LT, GTE, LTE, OVFL, UNCOND;
  - the flag bit index constants `FLAG_Z`, `FLAG_V`, `FLAG_N`.
- One sub-module, `branch_cond`, maps (`cond`, `flags`) to `hit`. It is purely combinational, so it can be reused and exhaustively tested.
- Arithmetic uses the existing 16-bit adder where `PC_W`==16. Otherwise it uses native `+`.

## Test plan
- Reset then 3 cycles with idle inputs: `pc` goes 0x0000 → 0x0002 → 0x0004 → 0x0006. `flush`=0 and `br_count`=0 throughout.
- `pc`=0x0010, `br`=1, `cond`=001, Z=1, `offset`=9'h1FE (−2): next `pc` = 0x0012 + (−4) = 0x000E. `flush`=1 for one cycle and `br_count`=1. Repeat with Z=0: next `pc`=0x0012 and no flush.
- Sweep all 8 `cond` × 8 `flags` combinations: `taken` matches the condition table. `cond`=111 is always taken.
- `br_reg`=1, `reg_target`=0x1234, `cond`=111: next `pc`=0x1234. With `stall`=1 on the same cycle, `pc` holds and `flush`=0.
- `hlt`=1 and `br`=1 at `pc`=0x0040: `halted`=1 and `pc` stays 0x0040 for 10 cycles. Asserting async `rst` mid-cycle forces `pc`=0x0000 and `halted`=0 before the next edge.
- Force `br_count` to saturate with `CNT_W`=2: after 3 taken branches it reads 3 and stays 3 after the 4th and 5th.
